// File: rtl/alu_issue_wb.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_wb
// Description : Single-issue front end for an external ALU. It reads operands
//               from a small register file, sequences IDLE/EXEC/WB and writes
//               the ALU result and flags back.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_wb #(
    parameter int WIDTH       = 16,
    parameter int OPCODE      = 4,
    parameter int REGS_CODING = 3,
    parameter int FLAGS       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [OPCODE-1:0]      req_opcode,
    input  logic [REGS_CODING-1:0] req_src1,
    input  logic [REGS_CODING-1:0] req_src2,
    input  logic [REGS_CODING-1:0] req_dest,
    input  logic                   req_imm_en,
    input  logic [WIDTH-1:0]       req_imm,
    output logic [OPCODE-1:0]      alu_opcode,
    output logic [WIDTH-1:0]       alu_op1,
    output logic [WIDTH-1:0]       alu_op2,
    output logic                   alu_cin,
    output logic [REGS_CODING-1:0] alu_dest_in,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic [FLAGS-1:0]       alu_flags,
    input  logic [REGS_CODING-1:0] alu_dest_out,
    output logic                   done,
    output logic [REGS_CODING-1:0] done_dest,
    output logic [WIDTH-1:0]       done_result,
    output logic [FLAGS-1:0]       flags_out,
    input  logic [REGS_CODING-1:0] dbg_addr,
    output logic [WIDTH-1:0]       dbg_data
);

    localparam int                c_NUM_REGS   = 1 << REGS_CODING;
    localparam int                c_FLAG_CARRY = 0;
    localparam logic [OPCODE-1:0] c_OP_CMP     = OPCODE'(4'b1100);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic                   w_accept;
    logic                   w_in_idle;
    logic                   w_in_wb;
    logic                   w_reg_we;

    logic [OPCODE-1:0]      r_opcode;
    logic [REGS_CODING-1:0] r_dest;
    logic [WIDTH-1:0]       r_op1;
    logic [WIDTH-1:0]       r_op2;
    logic                   r_cin;

    logic [WIDTH-1:0]       r_regs [c_NUM_REGS];
    logic [FLAGS-1:0]       r_flags;

    logic                   r_done;
    logic [REGS_CODING-1:0] r_done_dest;
    logic [WIDTH-1:0]       r_done_result;

    assign w_in_idle = (r_state == S_IDLE);
    assign w_in_wb   = (r_state == S_WB);

    // Ready is withheld while reset is held so nothing is accepted on that edge.
    assign req_ready = w_in_idle && !reset;
    assign w_accept  = req_valid && req_ready;

    // Compare only updates flags; every other opcode also writes the register.
    assign w_reg_we  = w_in_wb && (r_opcode != c_OP_CMP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_WB;
            S_WB:    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operands are captured at acceptance, so a dest that aliases a source
    // still feeds the ALU its pre-write value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode <= '0;
            r_dest   <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_cin    <= 1'b0;
        end else if (w_accept) begin
            r_opcode <= req_opcode;
            r_dest   <= req_dest;
            r_op1    <= r_regs[req_src1];
            r_op2    <= req_imm_en ? req_imm : r_regs[req_src2];
            r_cin    <= r_flags[c_FLAG_CARRY];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_reg_we) begin
            r_regs[alu_dest_out] <= alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags       <= '0;
            r_done        <= 1'b0;
            r_done_dest   <= '0;
            r_done_result <= '0;
        end else begin
            r_done <= w_in_wb;
            if (w_in_wb) begin
                r_flags       <= alu_flags;
                r_done_dest   <= alu_dest_out;
                r_done_result <= alu_result;
            end
        end
    end

    // The ALU sees a quiet bus while idle and stable operands through WB.
    assign alu_opcode  = w_in_idle ? '0   : r_opcode;
    assign alu_op1     = w_in_idle ? '0   : r_op1;
    assign alu_op2     = w_in_idle ? '0   : r_op2;
    assign alu_cin     = w_in_idle ? 1'b0 : r_cin;
    assign alu_dest_in = w_in_idle ? '0   : r_dest;

    assign done        = r_done;
    assign done_dest   = r_done_dest;
    assign done_result = r_done_result;
    assign flags_out   = r_flags;
    assign dbg_data    = r_regs[dbg_addr];

endmodule
`default_nettype wire
